// File: rtl/mem_bus_arb.sv
// mem_bus_arb: shares the single 64-bit memory bus between instruction fetch (IF)
// and the MEM stage load/store path. One transaction at a time; MEM has priority.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   if_req/if_addr                   fetch request (held until if_done)
//   if_rdata/if_done/stallreq_if     fetch response, done pulse, stall request
//   mem_req/we/addr/wdata/wstrb      load/store request (held until mem_done)
//   mem_rdata/mem_done/stallreq_mem  load response, done pulse, stall request
//   flush                            IF-side pipeline flush
//   bus_valid/we/addr/wdata/wstrb    bus request channel (out), bus_ready (in)
//   bus_rvalid/bus_rdata             bus response channel (in)
//   bus_err                          timeout pulse
//
// Optional feature: define ARB_TIMEOUT_EN to add an 8-bit transaction watchdog.
// Without it bus_err is tied 0 and the arbiter waits indefinitely.

module mem_bus_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic [63:0] if_rdata,
  output logic        if_done,
  output logic        stallreq_if,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [63:0] mem_addr,
  input  logic [63:0] mem_wdata,
  input  logic [7:0]  mem_wstrb,
  output logic [63:0] mem_rdata,
  output logic        mem_done,
  output logic        stallreq_mem,
  input  logic        flush,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_wstrb,
  input  logic        bus_ready,
  input  logic        bus_rvalid,
  input  logic [63:0] bus_rdata,
  output logic        bus_err
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;      // 0 = IF, 1 = MEM
  logic        discard_q, discard_d;
  logic        if_done_q, if_done_d;
  logic        mem_done_q, mem_done_d;
  logic [63:0] if_rdata_q, if_rdata_d;
  logic [63:0] mem_rdata_q, mem_rdata_d;
  logic        req_we_q, req_we_d;
  logic [63:0] req_addr_q, req_addr_d;
  logic [63:0] req_wdata_q, req_wdata_d;
  logic [7:0]  req_wstrb_q, req_wstrb_d;
  logic        fin;
  logic [63:0] fin_data;
  logic        discard_now;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    discard_d   = discard_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wstrb_d = req_wstrb_q;
    fin         = 1'b0;
    fin_data    = bus_rdata;
    // A flush seen in the completing cycle must also suppress the fetch.
    discard_now = discard_q | (flush & ~owner_q);
`ifdef ARB_TIMEOUT_EN
    cnt_d = (state_q == StIdle) ? cnt_q : cnt_q + 8'd1;
    err_d = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        discard_d = 1'b0;
        // No grant while a done pulse is out: the requester still holds req.
        if (!if_done_q && !mem_done_q) begin
          if (mem_req) begin
            state_d     = StReq;
            owner_d     = 1'b1;
            req_we_d    = mem_we;
            req_addr_d  = mem_addr;
            req_wdata_d = mem_wdata;
            req_wstrb_d = mem_wstrb;
`ifdef ARB_TIMEOUT_EN
            cnt_d = 8'd0;
`endif
          end else if (if_req && !flush) begin
            state_d     = StReq;
            owner_d     = 1'b0;
            req_we_d    = 1'b0;
            req_addr_d  = if_addr;
            req_wdata_d = 64'd0;
            req_wstrb_d = 8'hFF;
`ifdef ARB_TIMEOUT_EN
            cnt_d = 8'd0;
`endif
          end
        end
      end
      StReq: begin
        if (flush && !owner_q) discard_d = 1'b1;
        if (bus_ready) state_d = StWait;
      end
      StWait: begin
        if (flush && !owner_q) discard_d = 1'b1;
        if (bus_rvalid) fin = 1'b1;
      end
      default: state_d = StIdle;
    endcase

`ifdef ARB_TIMEOUT_EN
    if (!fin && state_q != StIdle && cnt_q == 8'd254) begin
      fin      = 1'b1;
      fin_data = 64'd0;
      err_d    = 1'b1;
    end
`endif

    if (fin) begin
      state_d = StIdle;
      if (owner_q) begin
        mem_done_d = 1'b1;
        if (!req_we_q) mem_rdata_d = fin_data;
      end else if (!discard_now) begin
        if_done_d  = 1'b1;
        if_rdata_d = fin_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      discard_q   <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      if_rdata_q  <= 64'd0;
      mem_rdata_q <= 64'd0;
      req_we_q    <= 1'b0;
      req_addr_q  <= 64'd0;
      req_wdata_q <= 64'd0;
      req_wstrb_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      discard_q   <= discard_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wstrb_q <= req_wstrb_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign bus_err = err_q;
`else
  assign bus_err = 1'b0;
`endif

  assign bus_valid    = (state_q == StReq);
  assign bus_we       = req_we_q;
  assign bus_addr     = req_addr_q;
  assign bus_wdata    = req_wdata_q;
  assign bus_wstrb    = req_wstrb_q;
  assign if_done      = if_done_q;
  assign mem_done     = mem_done_q;
  assign if_rdata     = if_rdata_q;
  assign mem_rdata    = mem_rdata_q;
  assign stallreq_if  = if_req & ~if_done_q;
  assign stallreq_mem = mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_bus_arb.sv
// Scoreboard bench for mem_bus_arb: stimulus pushes expected completions into a
// queue, a negedge monitor pops and compares on every done pulse.

module tb_mem_bus_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we, flush;
  logic [63:0] if_addr, mem_addr, mem_wdata, bus_rdata;
  logic [7:0]  mem_wstrb;
  logic        bus_ready, bus_rvalid;
  logic [63:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
  logic        if_done, mem_done, stallreq_if, stallreq_mem;
  logic        bus_valid, bus_we, bus_err;
  logic [7:0]  bus_wstrb;

  typedef struct packed {
    logic        port;  // 0 = IF, 1 = MEM
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   mon_en = 1'b0;

  mem_bus_arb dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .stallreq_if(stallreq_if),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .stallreq_mem(stallreq_mem), .flush(flush),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_ready(bus_ready), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: completions against the scoreboard, plus stall-request behaviour.
  always @(negedge clk) begin
    if (mon_en) begin
      if (if_done || mem_done) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_done: got if_done=%b mem_done=%b expected none",
                   if_done, mem_done);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_port", {63'd0, mem_done}, {63'd0, e.port});
          chk("done_rdata", e.port ? mem_rdata : if_rdata, e.data);
        end
      end
      chk("stallreq_if", {63'd0, stallreq_if}, {63'd0, if_req & ~if_done});
      chk("stallreq_mem", {63'd0, stallreq_mem}, {63'd0, mem_req & ~mem_done});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    @(negedge clk);
    while (!bus_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("valid_seen", {63'd0, bus_valid}, 64'd1);
  endtask

  task automatic chk_fields(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                            input logic [7:0] wstrb);
    chk("req_valid", {63'd0, bus_valid}, 64'd1);
    chk("req_we", {63'd0, bus_we}, {63'd0, we});
    chk("req_addr", bus_addr, addr);
    chk("req_wdata", bus_wdata, wdata);
    chk("req_wstrb", {56'd0, bus_wstrb}, {56'd0, wstrb});
  endtask

  // Serves one transaction; returns at the negedge of the (expected) done cycle.
  task automatic serve(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [7:0] wstrb, input int delay, input logic [63:0] rdata,
                       input bit flush_wait, output int n);
    wait_valid(n);
    for (int i = 0; i < delay; i++) begin
      chk_fields(we, addr, wdata, wstrb);
      @(negedge clk);
    end
    chk_fields(we, addr, wdata, wstrb);
    bus_ready = 1'b1;
    @(negedge clk);
    bus_ready = 1'b0;
    chk("wait_valid_low", {63'd0, bus_valid}, 64'd0);
    if (flush_wait) begin
      flush  = 1'b1;
      if_req = 1'b0;
      @(negedge clk);
      flush = 1'b0;
    end
    bus_rvalid = 1'b1;
    bus_rdata  = rdata;
    @(negedge clk);
    bus_rvalid = 1'b0;
  endtask

  initial begin
    int n;
    bit err_seen;
    rst = 1'b1; if_req = 0; mem_req = 0; mem_we = 0; flush = 0;
    if_addr = 0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0;
    bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {63'd0, bus_valid}, 64'd0);
    chk("rst_addr", bus_addr, 64'd0);
    chk("rst_wstrb", {56'd0, bus_wstrb}, 64'd0);
    chk("rst_if_rdata", if_rdata, 64'd0);
    chk("rst_dones", {62'd0, if_done, mem_done}, 64'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    // 1: single fetch at minimum latency
    cyc();
    if_req = 1; if_addr = 64'h8000_0000;
    exp_q.push_back('{port: 1'b0, data: 64'h0000_0013_0000_0093});
    serve(1'b0, 64'h8000_0000, 64'd0, 8'hFF, 0, 64'h0000_0013_0000_0093, 1'b0, n);
    chk("lat_valid", n, 1);
    chk("lat_done", {63'd0, if_done}, 64'd1);
    if_req = 0;

    // 2: simultaneous requests, MEM store first, then IF
    cyc();
    mem_req = 1; mem_we = 1; mem_addr = 64'h1000; mem_wdata = 64'h1122_3344; mem_wstrb = 8'h0F;
    if_req = 1; if_addr = 64'h8000_0008;
    exp_q.push_back('{port: 1'b1, data: 64'd0});
    exp_q.push_back('{port: 1'b0, data: 64'hAAAA_BBBB_CCCC_DDDD});
    serve(1'b1, 64'h1000, 64'h1122_3344, 8'h0F, 0, 64'hFFFF, 1'b0, n);
    mem_req = 0; mem_we = 0;
    serve(1'b0, 64'h8000_0008, 64'd0, 8'hFF, 0, 64'hAAAA_BBBB_CCCC_DDDD, 1'b0, n);
    chk("grant_after_mem_done", n, 1);
    if_req = 0;

    // 3: MEM load with bus_ready held off 5 cycles
    cyc();
    mem_req = 1; mem_addr = 64'h2468; mem_wdata = 64'h77; mem_wstrb = 8'h33;
    exp_q.push_back('{port: 1'b1, data: 64'hCAFE_F00D_1234_5678});
    serve(1'b0, 64'h2468, 64'h77, 8'h33, 5, 64'hCAFE_F00D_1234_5678, 1'b0, n);
    mem_req = 0;

    // 4: flushed fetch completes on the bus but is discarded
    cyc();
    if_req = 1; if_addr = 64'h8000_0010;
    serve(1'b0, 64'h8000_0010, 64'd0, 8'hFF, 0, 64'hDEAD, 1'b1, n);
    for (int i = 0; i < 3; i++) begin
      chk("flush_no_done", {63'd0, if_done}, 64'd0);
      chk("flush_rdata_kept", if_rdata, 64'hAAAA_BBBB_CCCC_DDDD);
      chk("flush_idle", {63'd0, bus_valid}, 64'd0);
      @(negedge clk);
    end

    // 5: reset in WAIT abandons the transaction
    mem_req = 1; mem_addr = 64'h3000;
    wait_valid(n);
    bus_ready = 1;
    @(negedge clk);
    bus_ready = 0;
    rst = 1; mem_req = 0;
    @(negedge clk);
    rst = 0; bus_rvalid = 1; bus_rdata = 64'h1234;
    @(negedge clk);
    bus_rvalid = 0;
    chk("rst_mid_outs", {bus_valid, bus_we, bus_wstrb, if_done, mem_done, bus_err}, 64'd0);
    chk("rst_mid_addr", bus_addr, 64'd0);
    chk("rst_mid_wdata", bus_wdata, 64'd0);
    chk("rst_mid_if_rdata", if_rdata, 64'd0);
    chk("rst_mid_mem_rdata", mem_rdata, 64'd0);
    @(negedge clk);
    chk("rst_mid_no_done", {62'd0, if_done, mem_done}, 64'd0);

    // 5b: arbiter usable after reset; leaves mem_rdata nonzero
    cyc();
    mem_req = 1; mem_addr = 64'h4000; mem_wstrb = 8'hFF;
    exp_q.push_back('{port: 1'b1, data: 64'h5555});
    serve(1'b0, 64'h4000, 64'h77, 8'hFF, 0, 64'h5555, 1'b0, n);
    mem_req = 0;

    // 6: bus never accepts
    cyc();
    mem_req = 1; mem_addr = 64'h5000;
    err_seen = 1'b0;
`ifdef ARB_TIMEOUT_EN
    exp_q.push_back('{port: 1'b1, data: 64'd0});
    n = 0;
    @(negedge clk);
    while (!bus_err && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", n, 256);
    chk("timeout_err_with_done", {62'd0, bus_err, mem_done}, 64'd3);
    mem_req = 0;
    @(negedge clk);
    chk("timeout_err_pulse", {63'd0, bus_err}, 64'd0);
`else
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus_err) err_seen = 1'b1;
    end
    chk("no_timeout_err", {63'd0, err_seen}, 64'd0);
    chk("still_waiting", {63'd0, bus_valid}, 64'd1);
    rst = 1; mem_req = 0;
    @(negedge clk);
    rst = 0;
`endif
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
